// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller slice.
// The VEND_AUDIT_EN build option adds sold/revenue counter widths used by vend_ctrl.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_e;

  localparam logic [1:0] ERR_BAD_ITEM  = 2'd0;
  localparam logic [1:0] ERR_SOLD_OUT  = 2'd1;
  localparam logic [1:0] ERR_NO_CREDIT = 2'd2;
  localparam logic [1:0] ERR_CFG_BUSY  = 2'd3;

  localparam int DEF_N_ITEMS  = 4;
  localparam int DEF_PRICE_W  = 4;
  localparam int DEF_QTY_W    = 4;
  localparam int DEF_CREDIT_W = 6;

  localparam int SOLD_W    = 16;
  localparam int REVENUE_W = 24;

endpackage

// File: rtl/vend_slot_table.sv
// Per-slot price/stock register file: one write port, one decrement port,
// and two combinational read ports (purchase lookup and external readback).
module vend_slot_table #(
  parameter int N_ITEMS = 4,
  parameter int PRICE_W = 4,
  parameter int QTY_W   = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [PRICE_W-1:0] i_wr_price,
  input  logic [QTY_W-1:0]   i_wr_qty,
  input  logic               i_dec_en,
  input  logic [IDX_W-1:0]   i_dec_idx,
  input  logic [IDX_W-1:0]   i_lk_idx,
  output logic [PRICE_W-1:0] o_lk_price,
  output logic [QTY_W-1:0]   o_lk_qty,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [PRICE_W-1:0] o_rd_price,
  output logic [QTY_W-1:0]   o_rd_qty
);

  localparam logic [IDX_W:0] LP_N = (IDX_W+1)'(N_ITEMS);

  logic [PRICE_W-1:0] r_price [N_ITEMS];
  logic [QTY_W-1:0]   r_qty   [N_ITEMS];
  logic               w_lk_ok;
  logic               w_rd_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        r_price[i] <= '0;
        r_qty[i]   <= '0;
      end
    end else begin
      if (i_wr_en) begin
        r_price[i_wr_idx] <= i_wr_price;
        r_qty[i_wr_idx]   <= i_wr_qty;
      end
      if (i_dec_en) begin
        r_qty[i_dec_idx] <= r_qty[i_dec_idx] - QTY_W'(1);
      end
    end
  end

  // Out-of-range indices read as an empty, free slot.
  assign w_lk_ok    = ({1'b0, i_lk_idx} < LP_N);
  assign w_rd_ok    = ({1'b0, i_rd_idx} < LP_N);
  assign o_lk_price = w_lk_ok ? r_price[i_lk_idx] : '0;
  assign o_lk_qty   = w_lk_ok ? r_qty[i_lk_idx]   : '0;
  assign o_rd_price = w_rd_ok ? r_price[i_rd_idx] : '0;
  assign o_rd_qty   = w_rd_ok ? r_qty[i_rd_idx]   : '0;

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit FSM, purchase validation, change handshake.
// Define VEND_AUDIT_EN to add per-slot sold counters and a revenue total.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_ITEMS  = DEF_N_ITEMS,
  parameter int PRICE_W  = DEF_PRICE_W,
  parameter int QTY_W    = DEF_QTY_W,
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int IDX_W    = $clog2(N_ITEMS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [PRICE_W-1:0]  coin_val,
  output logic                coin_reject,
  input  logic                buy_valid,
  input  logic [IDX_W-1:0]    buy_item,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_item,
  input  logic [PRICE_W-1:0]  cfg_price,
  input  logic [QTY_W-1:0]    cfg_qty,
  input  logic [IDX_W-1:0]    rd_item,
  output logic [PRICE_W-1:0]  rd_price,
  output logic [QTY_W-1:0]    rd_qty,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ack,
  output logic                err_valid,
  output logic [1:0]          err_code
`ifdef VEND_AUDIT_EN
  ,
  input  logic                audit_clr,
  output logic [SOLD_W-1:0]   rd_sold,
  output logic [REVENUE_W-1:0] revenue
`endif
);

  localparam logic [IDX_W:0] LP_N = (IDX_W+1)'(N_ITEMS);

  vend_state_e         r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [IDX_W-1:0]    r_item, w_item_nxt;
  logic                r_coin_rej, w_coin_rej_nxt;
  logic                r_err, w_err_nxt;
  logic [1:0]          r_err_code, w_err_code_nxt;

  logic                w_cfg_wr;
  logic                w_dec;
  logic                w_req_taken;
  logic                w_coin_live;
  logic                w_buy_bad;
  logic                w_cfg_bad;
  logic [IDX_W-1:0]    w_lk_idx;
  logic [PRICE_W-1:0]  w_lk_price;
  logic [QTY_W-1:0]    w_lk_qty;
  logic [CREDIT_W-1:0] w_price_ext;
  logic [CREDIT_W-1:0] w_credit_after;
  logic [CREDIT_W:0]   w_coin_sum;

  // The lookup port serves the buy check while collecting and the price deduction in VEND.
  assign w_lk_idx       = (r_state == VEND) ? r_item : buy_item;
  assign w_coin_live    = coin_valid && (coin_val != '0);
  assign w_buy_bad      = ({1'b0, buy_item} >= LP_N);
  assign w_cfg_bad      = ({1'b0, cfg_item} >= LP_N);
  assign w_price_ext    = CREDIT_W'(w_lk_price);
  assign w_credit_after = r_credit - w_price_ext;
  assign w_coin_sum     = {1'b0, r_credit} + (CREDIT_W+1)'(coin_val);

  vend_slot_table #(
    .N_ITEMS (N_ITEMS),
    .PRICE_W (PRICE_W),
    .QTY_W   (QTY_W),
    .IDX_W   (IDX_W)
  ) u_slots (
    .clk        (clk),
    .rst_n      (reset),
    .i_wr_en    (w_cfg_wr),
    .i_wr_idx   (cfg_item),
    .i_wr_price (cfg_price),
    .i_wr_qty   (cfg_qty),
    .i_dec_en   (w_dec),
    .i_dec_idx  (r_item),
    .i_lk_idx   (w_lk_idx),
    .o_lk_price (w_lk_price),
    .o_lk_qty   (w_lk_qty),
    .i_rd_idx   (rd_item),
    .o_rd_price (rd_price),
    .o_rd_qty   (rd_qty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_credit   <= '0;
      r_item     <= '0;
      r_coin_rej <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_item     <= w_item_nxt;
      r_coin_rej <= w_coin_rej_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_item_nxt     = r_item;
    w_coin_rej_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = '0;
    w_cfg_wr       = 1'b0;
    w_dec          = 1'b0;
    w_req_taken    = 1'b0;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (cancel && (r_state == COLLECT)) begin
          w_req_taken = 1'b1;
          w_state_nxt = CHANGE;
        end else if (buy_valid) begin
          w_req_taken = 1'b1;
          w_err_nxt   = 1'b1;
          if (w_buy_bad) begin
            w_err_code_nxt = ERR_BAD_ITEM;
          end else if (w_lk_qty == '0) begin
            w_err_code_nxt = ERR_SOLD_OUT;
          end else if (w_price_ext > r_credit) begin
            w_err_code_nxt = ERR_NO_CREDIT;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = VEND;
            w_item_nxt  = buy_item;
          end
        end else if (w_coin_live) begin
          if (w_coin_sum[CREDIT_W]) begin
            w_coin_rej_nxt = 1'b1;
          end else begin
            w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
            w_state_nxt  = COLLECT;
          end
        end
        if (w_req_taken && w_coin_live) begin
          w_coin_rej_nxt = 1'b1;
        end
        // A buy error already occupies the error pulse; the cfg request is then dropped silently.
        if (cfg_we && !w_err_nxt) begin
          if ((r_state != IDLE) || buy_valid) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_CFG_BUSY;
          end else if (w_cfg_bad) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_BAD_ITEM;
          end else begin
            w_cfg_wr = 1'b1;
          end
        end
      end
      VEND: begin
        w_dec          = 1'b1;
        w_credit_nxt   = w_credit_after;
        w_state_nxt    = (w_credit_after != '0) ? CHANGE : IDLE;
        w_coin_rej_nxt = w_coin_live;
        if (cfg_we) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_CFG_BUSY;
        end
      end
      CHANGE: begin
        if (change_ack) begin
          w_credit_nxt = '0;
          w_state_nxt  = IDLE;
        end
        w_coin_rej_nxt = w_coin_live;
        if (cfg_we) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_CFG_BUSY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign coin_reject  = r_coin_rej;
  assign credit       = r_credit;
  assign vend_valid   = (r_state == VEND);
  assign vend_item    = (r_state == VEND) ? r_item : '0;
  assign change_valid = (r_state == CHANGE);
  assign change_amt   = (r_state == CHANGE) ? r_credit : '0;
  assign err_valid    = r_err;
  assign err_code     = r_err_code;

`ifdef VEND_AUDIT_EN
  logic [SOLD_W-1:0]    r_sold [N_ITEMS];
  logic [REVENUE_W-1:0] r_revenue;
  logic [REVENUE_W:0]   w_rev_sum;
  logic                 w_rd_ok;

  assign w_rev_sum = {1'b0, r_revenue} + (REVENUE_W+1)'(w_lk_price);
  assign w_rd_ok   = ({1'b0, rd_item} < LP_N);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) r_sold[i] <= '0;
      r_revenue <= '0;
    end else if (audit_clr) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) r_sold[i] <= '0;
      r_revenue <= '0;
    end else if (r_state == VEND) begin
      if (r_sold[r_item] != '1) r_sold[r_item] <= r_sold[r_item] + SOLD_W'(1);
      r_revenue <= w_rev_sum[REVENUE_W] ? '1 : w_rev_sum[REVENUE_W-1:0];
    end
  end

  assign rd_sold = w_rd_ok ? r_sold[rd_item] : '0;
  assign revenue = r_revenue;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl at default parameters;
// audit counter checks are included when VEND_AUDIT_EN is defined.
module tb_vend_ctrl;

  localparam int N_ITEMS  = 4;
  localparam int PRICE_W  = 4;
  localparam int QTY_W    = 4;
  localparam int CREDIT_W = 6;
  localparam int IDX_W    = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                coin_valid;
  logic [PRICE_W-1:0]  coin_val;
  logic                coin_reject;
  logic                buy_valid;
  logic [IDX_W-1:0]    buy_item;
  logic                cancel;
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_item;
  logic [PRICE_W-1:0]  cfg_price;
  logic [QTY_W-1:0]    cfg_qty;
  logic [IDX_W-1:0]    rd_item;
  logic [PRICE_W-1:0]  rd_price;
  logic [QTY_W-1:0]    rd_qty;
  logic [CREDIT_W-1:0] credit;
  logic                vend_valid;
  logic [IDX_W-1:0]    vend_item;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                change_ack;
  logic                err_valid;
  logic [1:0]          err_code;
`ifdef VEND_AUDIT_EN
  logic                audit_clr;
  logic [15:0]         rd_sold;
  logic [23:0]         revenue;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_ctrl #(
    .N_ITEMS  (N_ITEMS),
    .PRICE_W  (PRICE_W),
    .QTY_W    (QTY_W),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .coin_reject  (coin_reject),
    .buy_valid    (buy_valid),
    .buy_item     (buy_item),
    .cancel       (cancel),
    .cfg_we       (cfg_we),
    .cfg_item     (cfg_item),
    .cfg_price    (cfg_price),
    .cfg_qty      (cfg_qty),
    .rd_item      (rd_item),
    .rd_price     (rd_price),
    .rd_qty       (rd_qty),
    .credit       (credit),
    .vend_valid   (vend_valid),
    .vend_item    (vend_item),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .change_ack   (change_ack),
    .err_valid    (err_valid),
    .err_code     (err_code)
`ifdef VEND_AUDIT_EN
    ,
    .audit_clr    (audit_clr),
    .rd_sold      (rd_sold),
    .revenue      (revenue)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0; coin_val  = '0;
    buy_valid  = 1'b0; buy_item  = '0;
    cancel     = 1'b0; change_ack = 1'b0;
    cfg_we     = 1'b0; cfg_item  = '0; cfg_price = '0; cfg_qty = '0;
    rd_item    = '0;
`ifdef VEND_AUDIT_EN
    audit_clr  = 1'b0;
`endif
  endtask

  task automatic do_coin(input int v);
    coin_valid = 1'b1; coin_val = PRICE_W'(v);
    tick();
    coin_valid = 1'b0; coin_val = '0;
  endtask

  task automatic do_cfg(input int idx, input int p, input int q);
    cfg_we = 1'b1; cfg_item = IDX_W'(idx); cfg_price = PRICE_W'(p); cfg_qty = QTY_W'(q);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_buy(input int idx);
    buy_valid = 1'b1; buy_item = IDX_W'(idx);
    tick();
    buy_valid = 1'b0;
  endtask

  task automatic do_ack();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int idx, input int p, input int q);
    rd_item = IDX_W'(idx);
    #1;
    chk({tag, "_price"}, 32'(rd_price), 32'(p));
    chk({tag, "_qty"}, 32'(rd_qty), 32'(q));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #12;
    chk("rst_credit", 32'(credit), 0);
    chk("rst_vend", 32'(vend_valid), 0);
    chk("rst_change", 32'(change_valid), 0);
    chk("rst_rej", 32'(coin_reject), 0);
    chk("rst_err", 32'(err_valid), 0);
    reset = 1'b1;
    tick();

    do_cfg(1, 5, 2);
    chk("cfg_noerr", 32'(err_valid), 0);
    do_cfg(0, 9, 3);
    do_cfg(2, 3, 0);
    rd_chk("cfg1", 1, 5, 2);

    // Coins 2,2,3 then buy slot1 (price 5): change 2.
    do_coin(2);
    chk("t1_credit2", 32'(credit), 2);
    do_coin(2);
    do_coin(3);
    chk("t1_credit7", 32'(credit), 7);
    do_buy(1);
    chk("t1_vend", 32'(vend_valid), 1);
    chk("t1_item", 32'(vend_item), 1);
    tick();
    chk("t1_vend_end", 32'(vend_valid), 0);
    chk("t1_chg_v", 32'(change_valid), 1);
    chk("t1_chg_amt", 32'(change_amt), 2);
    rd_chk("t1_slot1", 1, 5, 1);
    tick();
    chk("t1_chg_hold", 32'(change_amt), 2);
    do_ack();
    chk("t1_chg_drop", 32'(change_valid), 0);
    chk("t1_credit0", 32'(credit), 0);

    // Sold-out refusal, then cancel refunds everything.
    do_coin(4);
    do_coin(3);
    do_buy(2);
    chk("t2_err", 32'(err_valid), 1);
    chk("t2_code", 32'(err_code), 1);
    chk("t2_credit", 32'(credit), 7);
    tick();
    chk("t2_err_pulse", 32'(err_valid), 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t2_chg_v", 32'(change_valid), 1);
    chk("t2_chg_amt", 32'(change_amt), 7);
    do_ack();
    chk("t2_credit0", 32'(credit), 0);

    // Insufficient credit, top up, exact-price vend skips change.
    do_coin(4);
    do_buy(0);
    chk("t3_err", 32'(err_valid), 1);
    chk("t3_code", 32'(err_code), 2);
    chk("t3_credit", 32'(credit), 4);
    do_coin(5);
    chk("t3_credit9", 32'(credit), 9);
    do_buy(0);
    chk("t3_vend", 32'(vend_valid), 1);
    chk("t3_item", 32'(vend_item), 0);
    tick();
    chk("t3_nochg", 32'(change_valid), 0);
    chk("t3_credit0", 32'(credit), 0);
    rd_chk("t3_slot0", 0, 9, 2);

    // Credit overflow reject; coin alongside a buy is rejected.
    for (int i = 0; i < 4; i++) do_coin(15);
    chk("t4_credit60", 32'(credit), 60);
    do_coin(8);
    chk("t4_ovf_rej", 32'(coin_reject), 1);
    chk("t4_ovf_credit", 32'(credit), 60);
    buy_valid = 1'b1; buy_item = 2'd1; coin_valid = 1'b1; coin_val = 4'd3;
    tick();
    buy_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
    chk("t4_buy_rej", 32'(coin_reject), 1);
    chk("t4_vend", 32'(vend_valid), 1);
    chk("t4_credit", 32'(credit), 60);
    tick();
    chk("t4_chg_amt", 32'(change_amt), 55);
    rd_chk("t4_slot1", 1, 5, 0);

    // Config and coin during CHANGE, then async reset mid-CHANGE.
    cfg_we = 1'b1; cfg_item = 2'd3; cfg_price = 4'd7; cfg_qty = 4'd7;
    coin_valid = 1'b1; coin_val = 4'd2;
    tick();
    cfg_we = 1'b0; coin_valid = 1'b0; coin_val = '0;
    chk("t5_err", 32'(err_valid), 1);
    chk("t5_code", 32'(err_code), 3);
    chk("t5_rej", 32'(coin_reject), 1);
    chk("t5_chg_amt", 32'(change_amt), 55);
    rd_chk("t5_slot3", 3, 0, 0);
    reset = 1'b0;
    #1;
    chk("t5_rst_chg", 32'(change_valid), 0);
    chk("t5_rst_amt", 32'(change_amt), 0);
    chk("t5_rst_credit", 32'(credit), 0);
    chk("t5_rst_err", 32'(err_valid), 0);
    rd_chk("t5_rst_slot0", 0, 0, 0);
    reset = 1'b1;
    tick();

`ifdef VEND_AUDIT_EN
    do_cfg(1, 5, 5);
    for (int i = 0; i < 2; i++) begin
      do_coin(5);
      do_buy(1);
      tick();
    end
    rd_item = 2'd1;
    #1;
    chk("au_sold", 32'(rd_sold), 2);
    chk("au_rev", 32'(revenue), 10);
    audit_clr = 1'b1;
    tick();
    audit_clr = 1'b0;
    chk("au_sold_clr", 32'(rd_sold), 0);
    chk("au_rev_clr", 32'(revenue), 0);
`endif

    // Free slot vends from IDLE; a same-cycle cfg is refused and not written.
    do_cfg(3, 0, 1);
    buy_valid = 1'b1; buy_item = 2'd3;
    cfg_we = 1'b1; cfg_item = 2'd2; cfg_price = 4'd9; cfg_qty = 4'd9;
    tick();
    buy_valid = 1'b0; cfg_we = 1'b0;
    chk("t6_vend", 32'(vend_valid), 1);
    chk("t6_item", 32'(vend_item), 3);
    chk("t6_err", 32'(err_valid), 1);
    chk("t6_code", 32'(err_code), 3);
    tick();
    chk("t6_idle_chg", 32'(change_valid), 0);
    chk("t6_credit", 32'(credit), 0);
    rd_chk("t6_slot2", 2, 0, 0);
    rd_chk("t6_slot3", 3, 0, 0);
    do_buy(3);
    chk("t6_sold_err", 32'(err_valid), 1);
    chk("t6_sold_code", 32'(err_code), 1);

    // Zero coin ignored; cancel in IDLE does not block a coin; stray ack ignored.
    do_coin(0);
    chk("t7_zero_rej", 32'(coin_reject), 0);
    chk("t7_zero_credit", 32'(credit), 0);
    cancel = 1'b1; coin_valid = 1'b1; coin_val = 4'd3;
    tick();
    cancel = 1'b0; coin_valid = 1'b0; coin_val = '0;
    chk("t7_idle_cancel_rej", 32'(coin_reject), 0);
    chk("t7_idle_cancel_credit", 32'(credit), 3);
    chk("t7_idle_cancel_chg", 32'(change_valid), 0);
    do_ack();
    chk("t7_stray_ack", 32'(credit), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Parametrised clocked vending controller: N_ITEMS slots, each holding a price and a stock count.
- Accumulates coin credit, validates purchases, decrements stock and returns change through a handshake.
- Sits between the coin/keypad front end and the dispenser/display logic.
- Single FSM owns credit; slot table is writable only while idle.

Parameters:
- N_ITEMS, 4: number of product slots (2..16).
- PRICE_W, 4: bit width of a slot price and of coin_val.
- QTY_W, 4: bit width of a slot stock count.
- CREDIT_W, 6: bit width of the credit accumulator (must be ≥ PRICE_W).
- IDX_W, $clog2(N_ITEMS): bit width of slot index ports (derived).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coin_valid  in  1  coin inserted this cycle
- coin_val  in  PRICE_W  coin value
- coin_reject  out  1  one-cycle pulse: coin not accepted (return it)
- buy_valid  in  1  purchase request
- buy_item  in  IDX_W  requested slot
- cancel  in  1  abort and refund all credit
- cfg_we  in  1  slot write strobe
- cfg_item  in  IDX_W  slot to write
- cfg_price  in  PRICE_W  new price
- cfg_qty  in  QTY_W  new stock
- rd_item  in  IDX_W  slot readback select
- rd_price  out  PRICE_W  price of rd_item (combinational)
- rd_qty  out  QTY_W  stock of rd_item (combinational)
- credit  out  CREDIT_W  current credit (registered)
- vend_valid  out  1  one-cycle pulse: dispense
- vend_item  out  IDX_W  slot dispensed; valid with vend_valid
- change_valid  out  1  change pending
- change_amt  out  CREDIT_W  change value; stable while change_valid
- change_ack  in  1  change paid out
- err_valid  out  1  one-cycle pulse: request refused
- err_code  out  2  0 BAD_ITEM, 1 SOLD_OUT, 2 NO_CREDIT, 3 CFG_BUSY

Behaviour:
- Reset (reset=0, async): state IDLE; credit=0; all slot price/qty=0; all outputs 0.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, CHANGE.
- Per-cycle request priority in IDLE/COLLECT: cancel > buy_valid > coin_valid.
  - A coin in the same cycle as an accepted cancel or buy gets coin_reject and is not added.
- Coin handling:
  - Coin in IDLE/COLLECT adds to credit next cycle.
  - If credit+coin_val exceeds 2^CREDIT_W-1: coin_reject, credit unchanged.
  - Coin with coin_val==0 is ignored (no reject).
  - IDLE→COLLECT when credit becomes nonzero.
- Buy handling (IDLE or COLLECT), evaluated in this order:
  - buy_item ≥ N_ITEMS → err BAD_ITEM.
  - qty==0 → err SOLD_OUT.
  - price > credit → err NO_CREDIT.
  - Otherwise → VEND.
  - A refused buy leaves state and credit unchanged.
  - A price-0 slot with stock vends from IDLE with zero credit.
- VEND (exactly 1 cycle):
  - vend_valid=1, vend_item=slot.
  - Slot qty decremented; credit -= price (same edge).
  - Next state: CHANGE if remaining credit>0, else IDLE.
- cancel:
  - In COLLECT → CHANGE with full credit.
  - In IDLE: no effect.
- CHANGE:
  - change_valid=1, change_amt=credit, held until change_ack.
  - On the ack cycle: credit=0, change_valid drops next cycle, state→IDLE.
  - change_ack outside CHANGE is ignored.
- VEND/CHANGE: coin_valid → coin_reject; buy_valid/cancel ignored (no error).
- cfg_we:
  - Honoured only in IDLE; writes price and qty next cycle.
  - Otherwise err CFG_BUSY and no write.
  - cfg_item ≥ N_ITEMS → err BAD_ITEM.
  - cfg_we and buy_valid in the same IDLE cycle: buy wins, cfg → CFG_BUSY.
- Stock decrements never wrap: qty==0 is refused before VEND.
- At most one err_valid pulse per cycle; buy errors take precedence over cfg errors.
- Async reset mid-transaction discards credit without change output.

Optional Feature:
- Macro: VEND_AUDIT_EN.
- When defined:
  - Adds per-slot sold counters (16 bit, saturating) and a total revenue counter (24 bit, saturating).
  - Each VEND increments the sold counter and adds price to revenue.
  - New outputs: rd_sold (16 bit, selected by rd_item) and revenue (24 bit).
  - New input audit_clr: synchronous clear of all counters, honoured in any state; if coincident with VEND, the clear wins.
  - All counters are 0 on reset.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package vend_pkg:
  - State enum (IDLE, COLLECT, VEND, CHANGE).
  - err_code constants (ERR_BAD_ITEM, ERR_SOLD_OUT, ERR_NO_CREDIT, ERR_CFG_BUSY).
  - Default width constants.
- Sub-module vend_slot_table:
  - N_ITEMS×(PRICE_W+QTY_W) register array.
  - Write port, decrement port, two read ports (buy lookup and rd_item).
  - Reset to zero.
- The FSM, credit and change logic stay in vend_ctrl.

Test Plan:
- Config slot1 price=5 qty=2; coins 2,2,3; buy 1 → vend_valid with vend_item=1; then change_valid with change_amt=2; ack → credit=0, slot1 qty=1, state IDLE.
- Slot2 qty=0, credit=7; buy 2 → err SOLD_OUT, credit stays 7; cancel → change_amt=7.
- Slot0 price=9, credit=4; buy 0 → err NO_CREDIT; coin 5 → credit 9; buy 0 → vend, no change phase.
- Credit 60 (CREDIT_W=6), coin 8 → coin_reject, credit 60; coin in same cycle as buy → coin_reject, buy proceeds.
- During CHANGE: cfg_we → CFG_BUSY; coin → reject. Async reset asserted mid-CHANGE → all outputs 0 and slots cleared immediately.
- VEND_AUDIT_EN defined: two vends of price 5 at slot1 → rd_sold=2, revenue=10; audit_clr → both 0.
